// File: rtl/grid_map_ctrl_if.sv
// rtl/grid_map_ctrl_if.sv - game-side bus of the grid map controller
// master: gamepad/level loader/robot FSM side; slave: the map controller.
interface grid_map_ctrl_if #(
  parameter int ROWS        = 10,
  parameter int COLS        = 20,
  parameter int CELL_W      = 3,
  parameter int BARRIER_MAX = 20
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = $clog2(BARRIER_MAX + 1);

  logic              v_sync;
  logic [11:0]       gamepad_input;
  logic              init_we;
  logic [RW-1:0]     init_row;
  logic [CW-1:0]     init_col;
  logic [CELL_W-1:0] init_data;
  logic [RW-1:0]     robot_row;
  logic [CW-1:0]     robot_col;
  logic [1:0]        robot_dir;
  logic              remove_req;

  logic [RW-1:0]     cursor_row;
  logic [CW-1:0]     cursor_col;
  logic              flag_mode;
  logic              read_armed;
  logic              head_out;
  logic              left_out;
  logic              under_out;
  logic              barrier_out;
  logic [BW-1:0]     barrier_counter;

  modport master (
    output v_sync, gamepad_input, init_we, init_row, init_col, init_data,
           robot_row, robot_col, robot_dir, remove_req,
    input  cursor_row, cursor_col, flag_mode, read_armed, head_out,
           left_out, under_out, barrier_out, barrier_counter
  );

  modport slave (
    input  v_sync, gamepad_input, init_we, init_row, init_col, init_data,
           robot_row, robot_col, robot_dir, remove_req,
    output cursor_row, cursor_col, flag_mode, read_armed, head_out,
           left_out, under_out, barrier_out, barrier_counter
  );
endinterface

// File: rtl/grid_map_ctrl.sv
// rtl/grid_map_ctrl.sv - robot/trash game map: grid store, edit cursor, barriers, sensors
// Gamepad commands are taken on v_sync rising edges and need an all-released edge to re-arm.
module grid_map_ctrl #(
  parameter int ROWS        = 10,
  parameter int COLS        = 20,
  parameter int CELL_W      = 3,
  parameter int BARRIER_MAX = 20
) (
  input logic clock,
  input logic reset,
  grid_map_ctrl_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int BW = $clog2(BARRIER_MAX + 1);

  localparam logic [11:0]       USED_MASK    = 12'hA0F;
  localparam logic [RW:0]       ROWS_L       = (RW+1)'(ROWS);
  localparam logic [CW:0]       COLS_L       = (CW+1)'(COLS);
  localparam logic [RW-1:0]     ROW_LAST     = RW'(ROWS - 1);
  localparam logic [CW-1:0]     COL_LAST     = CW'(COLS - 1);
  localparam logic [BW-1:0]     BARRIER_LIM  = BW'(BARRIER_MAX);
  localparam logic [CELL_W-1:0] CELL_FREE    = CELL_W'(0);
  localparam logic [CELL_W-1:0] CELL_BARRIER = CELL_W'(2);
  localparam logic [CELL_W-1:0] CELL_TRASH   = CELL_W'(3);

  typedef enum logic [2:0] {
    CMD_NONE, CMD_MODE, CMD_BARRIER, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT
  } cmd_t;

  // Flat row-major cell store so reset is a single vector clear.
  logic [ROWS*COLS*CELL_W-1:0] grid;

  logic          vsPrev;
  logic [RW-1:0] cursorRow;
  logic [CW-1:0] cursorCol;
  logic          flagMode;
  logic          readArmed;
  logic [BW-1:0] barrierCount;
  logic          headReg, leftReg, underReg, barrierReg;

  function automatic int cellBase(input logic [RW:0] r, input logic [CW:0] c);
    return (int'(r) * COLS + int'(c)) * CELL_W;
  endfunction

  function automatic logic [CELL_W-1:0] cellAt(input logic [RW:0] r, input logic [CW:0] c);
    return grid[cellBase(r, c) +: CELL_W];
  endfunction

  function automatic logic blocksRobot(input logic [CELL_W-1:0] code);
    return (code != CELL_FREE) && (code != CELL_TRASH);
  endfunction

  function automatic logic [RW:0] stepRow(input logic [1:0] d, input logic [RW-1:0] r);
    case (d)
      2'd0:    return {1'b0, r} - (RW+1)'(1);
      2'd2:    return {1'b0, r} + (RW+1)'(1);
      default: return {1'b0, r};
    endcase
  endfunction

  function automatic logic [CW:0] stepCol(input logic [1:0] d, input logic [CW-1:0] c);
    case (d)
      2'd1:    return {1'b0, c} + (CW+1)'(1);
      2'd3:    return {1'b0, c} - (CW+1)'(1);
      default: return {1'b0, c};
    endcase
  endfunction

  logic [11:0] padUsed;
  logic        vsEdge, accept, rearm;
  cmd_t        cmd;

  assign padUsed = bus.gamepad_input & USED_MASK;
  assign vsEdge  = bus.v_sync & ~vsPrev;
  assign accept  = vsEdge & readArmed & (|padUsed);
  assign rearm   = vsEdge & ~readArmed & ~(|padUsed);

  always_comb begin
    cmd = CMD_NONE;
    if      (padUsed[11]) cmd = CMD_MODE;
    else if (padUsed[9])  cmd = CMD_BARRIER;
    else if (padUsed[0])  cmd = CMD_UP;
    else if (padUsed[1])  cmd = CMD_DOWN;
    else if (padUsed[2])  cmd = CMD_LEFT;
    else if (padUsed[3])  cmd = CMD_RIGHT;
  end

  logic              initHit, robotIn, remHit, onRobot, initOnCursor;
  logic              padPlace, padClear, padWrite;
  logic [CELL_W-1:0] robotCell, cursorCell;

  always_comb begin
    initHit      = bus.init_we && ({1'b0, bus.init_row} < ROWS_L) && ({1'b0, bus.init_col} < COLS_L);
    robotIn      = ({1'b0, bus.robot_row} < ROWS_L) && ({1'b0, bus.robot_col} < COLS_L);
    robotCell    = robotIn ? cellAt({1'b0, bus.robot_row}, {1'b0, bus.robot_col}) : CELL_FREE;
    cursorCell   = cellAt({1'b0, cursorRow}, {1'b0, cursorCol});
    onRobot      = (cursorRow == bus.robot_row) && (cursorCol == bus.robot_col);
    initOnCursor = initHit && (bus.init_row == cursorRow) && (bus.init_col == cursorCol);
    remHit       = bus.remove_req && robotIn && (robotCell == CELL_TRASH) &&
                   !(initHit && (bus.init_row == bus.robot_row) && (bus.init_col == bus.robot_col));
    padPlace     = accept && !flagMode && (cmd == CMD_BARRIER) && (cursorCell == CELL_FREE) &&
                   (barrierCount < BARRIER_LIM) && !onRobot;
    padClear     = accept && !flagMode && (cmd == CMD_BARRIER) && (cursorCell == CELL_BARRIER);
    // Higher-priority writers on the cursor cell swallow the toggle, counter included.
    padWrite     = (padPlace || padClear) && !initOnCursor && !(remHit && onRobot);
  end

  logic [1:0]        leftDir;
  logic [RW:0]       headR, leftR;
  logic [CW:0]       headC, leftC;
  logic              headOff, leftOff;
  logic [CELL_W-1:0] headCell, leftCell;

  always_comb begin
    leftDir  = bus.robot_dir + 2'd3;
    headR    = stepRow(bus.robot_dir, bus.robot_row);
    headC    = stepCol(bus.robot_dir, bus.robot_col);
    leftR    = stepRow(leftDir, bus.robot_row);
    leftC    = stepCol(leftDir, bus.robot_col);
    headOff  = (headR >= ROWS_L) || (headC >= COLS_L);
    leftOff  = (leftR >= ROWS_L) || (leftC >= COLS_L);
    headCell = headOff ? CELL_FREE : cellAt(headR, headC);
    leftCell = leftOff ? CELL_FREE : cellAt(leftR, leftC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grid         <= '0;
      vsPrev       <= 1'b0;
      cursorRow    <= '0;
      cursorCol    <= '0;
      flagMode     <= 1'b0;
      readArmed    <= 1'b1;
      barrierCount <= '0;
      headReg      <= 1'b0;
      leftReg      <= 1'b0;
      underReg     <= 1'b0;
      barrierReg   <= 1'b0;
    end else begin
      vsPrev <= bus.v_sync;

      if (padWrite)
        grid[cellBase({1'b0, cursorRow}, {1'b0, cursorCol}) +: CELL_W] <= padPlace ? CELL_BARRIER : CELL_FREE;
      if (remHit)
        grid[cellBase({1'b0, bus.robot_row}, {1'b0, bus.robot_col}) +: CELL_W] <= CELL_FREE;
      if (initHit)
        grid[cellBase({1'b0, bus.init_row}, {1'b0, bus.init_col}) +: CELL_W] <= bus.init_data;

      if (padWrite && padPlace)
        barrierCount <= barrierCount + BW'(1);
      else if (padWrite && padClear && barrierCount != '0)
        barrierCount <= barrierCount - BW'(1);

      if (accept) begin
        readArmed <= 1'b0;
        case (cmd)
          CMD_MODE:  flagMode <= ~flagMode;
          CMD_UP:    if (!flagMode && cursorRow != '0)       cursorRow <= cursorRow - RW'(1);
          CMD_DOWN:  if (!flagMode && cursorRow != ROW_LAST) cursorRow <= cursorRow + RW'(1);
          CMD_LEFT:  if (!flagMode && cursorCol != '0)       cursorCol <= cursorCol - CW'(1);
          CMD_RIGHT: if (!flagMode && cursorCol != COL_LAST) cursorCol <= cursorCol + CW'(1);
          default: ;
        endcase
      end else if (rearm) begin
        readArmed <= 1'b1;
      end

      headReg    <= headOff || blocksRobot(headCell);
      leftReg    <= leftOff || blocksRobot(leftCell);
      barrierReg <= !headOff && (headCell == CELL_BARRIER);
      underReg   <= robotIn && (robotCell == CELL_TRASH);
    end
  end

  assign bus.cursor_row      = cursorRow;
  assign bus.cursor_col      = cursorCol;
  assign bus.flag_mode       = flagMode;
  assign bus.read_armed      = readArmed;
  assign bus.head_out        = headReg;
  assign bus.left_out        = leftReg;
  assign bus.under_out       = underReg;
  assign bus.barrier_out     = barrierReg;
  assign bus.barrier_counter = barrierCount;
endmodule
